// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
// Op codes 000-101 are the same as the legacy combinational shifter.
package shifter_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ROL  = 3'b001;
    localparam logic [2:0] OP_ROR  = 3'b010;
    localparam logic [2:0] OP_LSL  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_LSR  = 3'b101;
    localparam logic [2:0] OP_RCL  = 3'b110;
    localparam logic [2:0] OP_RCR  = 3'b111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift/rotate step. The carry tracks the bit
// that leaves the word; the RCL/RCR ops treat {c, word} as a WIDTH+1-bit ring.
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    always_comb begin
        out  = in;
        cout = cin;
        case (op)
            OP_PASS: ;
            OP_ROL: begin
                out  = {in[WIDTH-2:0], in[WIDTH-1]};
                cout = in[WIDTH-1];
            end
            OP_ROR: begin
                out  = {in[0], in[WIDTH-1:1]};
                cout = in[0];
            end
            OP_LSL: begin
                out  = {in[WIDTH-2:0], 1'b0};
                cout = in[WIDTH-1];
            end
            OP_ASR: begin
                out  = {in[WIDTH-1], in[WIDTH-1:1]};
                cout = in[0];
            end
            OP_LSR: begin
                out  = {1'b0, in[WIDTH-1:1]};
                cout = in[0];
            end
            OP_RCL: begin
                out  = {in[WIDTH-2:0], cin};
                cout = in[WIDTH-1];
            end
            OP_RCR: begin
                out  = {cin, in[WIDTH-1:1]};
                cout = in[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: one bit position per clock under a start/done handshake.
// Holds the control FSM, the step counter and the result/carry/zero registers.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] din,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             cout,
    output logic             zero
);

    logic [1:0]       state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             c_q, c_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] step_out;
    logic             step_c;
    logic             accept;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op  (op_q),
        .in  (reg_q),
        .cin (c_q),
        .out (step_out),
        .cout(step_c)
    );

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        reg_d   = reg_q;
        c_d     = c_q;
        zero_d  = zero_q;

        case (state_q)
            S_SHIFT: begin
                reg_d = step_out;
                c_d   = step_c;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: ;
        endcase

        if (accept) begin
            reg_d   = din;
            c_d     = cin;
            state_d = S_SHIFT;
            // amt=0 still costs one cycle, spent as a single pass step.
            if (amt == '0) begin
                op_d  = OP_PASS;
                cnt_d = AMT_W'(1);
            end else begin
                op_d  = op;
                cnt_d = amt;
            end
        end

        if (state_d == S_DONE) begin
            zero_d = (reg_d == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_PASS;
            reg_q   <= '0;
            c_q     <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            reg_q   <= reg_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign dout = reg_q;
    assign cout = c_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter at WIDTH=8.
module tb_iter_shifter;
    import shifter_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [2:0] amt;
    logic [7:0] din;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] dout;
    logic       cout;
    logic       zero;

    int checks;
    int passes;

    iter_shifter #(
        .WIDTH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .amt  (amt),
        .din  (din),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .dout (dout),
        .cout (cout),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a request across one rising edge (E0); returns 1 ns after it.
    task automatic launch(input logic [2:0] o, input logic [2:0] a, input logic [7:0] d,
                          input logic c);
        op    = o;
        amt   = a;
        din   = d;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges after E0 until done is seen; -1 if it never shows up.
    task automatic wait_done(input int already, output int lat);
        int k;
        lat = -1;
        k   = already;
        while (lat < 0 && k < already + 40) begin
            @(posedge clk);
            #1;
            k++;
            if (done) lat = k;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, dout, cout, zero} !== 12'h000)
            $display("FAIL reset_values: got busy=%b done=%b dout=%h cout=%b zero=%b, want all 0",
                     busy, done, dout, cout, zero);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00)
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        else passes++;
    endtask

    task automatic test_rol();
        int lat;
        launch(OP_ROL, 3'd1, 8'h81, 1'b0);
        wait_done(0, lat);
        checks++;
        if (lat !== 1) $display("FAIL rol_latency: got %0d, want 1", lat);
        else passes++;
        checks++;
        if ({dout, cout, zero} !== {8'h03, 1'b1, 1'b0})
            $display("FAIL rol_result: got dout=%h cout=%b zero=%b, want 03 1 0", dout, cout, zero);
        else passes++;
    endtask

    task automatic test_asr();
        launch(OP_ASR, 3'd3, 8'h90, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b10) $display("FAIL asr_busy_c1: got busy=%b done=%b, want 1 0", busy, done);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b10) $display("FAIL asr_busy_c2: got busy=%b done=%b, want 1 0", busy, done);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b01) $display("FAIL asr_done_c3: got busy=%b done=%b, want 0 1", busy, done);
        else passes++;
        checks++;
        if ({dout, cout, zero} !== {8'hF2, 1'b0, 1'b0})
            $display("FAIL asr_result: got dout=%h cout=%b zero=%b, want f2 0 0", dout, cout, zero);
        else passes++;
    endtask

    task automatic test_rotate_carry();
        int lat;
        launch(OP_RCL, 3'd2, 8'h80, 1'b0);
        wait_done(0, lat);
        checks++;
        if (lat !== 2 || dout !== 8'h01 || cout !== 1'b0)
            $display("FAIL rcl: got lat=%0d dout=%h cout=%b, want 2 01 0", lat, dout, cout);
        else passes++;
        launch(OP_RCR, 3'd1, 8'h01, 1'b1);
        wait_done(0, lat);
        checks++;
        if (lat !== 1 || dout !== 8'h80 || cout !== 1'b1)
            $display("FAIL rcr: got lat=%0d dout=%h cout=%b, want 1 80 1", lat, dout, cout);
        else passes++;
    endtask

    task automatic test_zero_and_amt0();
        int lat;
        launch(OP_LSR, 3'd1, 8'h01, 1'b0);
        wait_done(0, lat);
        checks++;
        if (lat !== 1 || dout !== 8'h00 || cout !== 1'b1 || zero !== 1'b1)
            $display("FAIL lsr_zero: got lat=%0d dout=%h cout=%b zero=%b, want 1 00 1 1",
                     lat, dout, cout, zero);
        else passes++;
        launch(OP_LSL, 3'd0, 8'h5A, 1'b1);
        wait_done(0, lat);
        checks++;
        if (lat !== 1 || dout !== 8'h5A || cout !== 1'b1 || zero !== 1'b0)
            $display("FAIL lsl_amt0: got lat=%0d dout=%h cout=%b zero=%b, want 1 5a 1 0",
                     lat, dout, cout, zero);
        else passes++;
        launch(OP_PASS, 3'd3, 8'h3C, 1'b1);
        wait_done(0, lat);
        checks++;
        if (lat !== 3 || dout !== 8'h3C || cout !== 1'b1)
            $display("FAIL pass_amt3: got lat=%0d dout=%h cout=%b, want 3 3c 1", lat, dout, cout);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int lat;
        launch(OP_ROR, 3'd7, 8'h0F, 1'b1);
        @(posedge clk);
        #1;
        // Request during SHIFT must be dropped.
        launch(OP_LSL, 3'd3, 8'hFF, 1'b0);
        wait_done(2, lat);
        checks++;
        if (lat !== 7 || dout !== 8'h1E || cout !== 1'b0)
            $display("FAIL ror_ignore_start: got lat=%0d dout=%h cout=%b, want 7 1e 0",
                     lat, dout, cout);
        else passes++;
        launch(OP_ROL, 3'd2, 8'h01, 1'b0);
        wait_done(0, lat);
        checks++;
        if (lat !== 2 || dout !== 8'h04 || cout !== 1'b0)
            $display("FAIL b2b_rol: got lat=%0d dout=%h cout=%b, want 2 04 0", lat, dout, cout);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || dout !== 8'h04)
            $display("FAIL idle_hold: got done=%b busy=%b dout=%h, want 0 0 04", done, busy, dout);
        else passes++;
    endtask

    task automatic test_mid_reset();
        int lat;
        launch(OP_LSL, 3'd7, 8'h03, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, dout, cout, zero} !== 12'h000)
            $display("FAIL mid_reset: got busy=%b done=%b dout=%h cout=%b zero=%b, want all 0",
                     busy, done, dout, cout, zero);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        launch(OP_LSL, 3'd7, 8'h03, 1'b0);
        wait_done(0, lat);
        checks++;
        if (lat !== 7 || dout !== 8'h80 || cout !== 1'b1 || zero !== 1'b0)
            $display("FAIL after_reset: got lat=%0d dout=%h cout=%b zero=%b, want 7 80 1 0",
                     lat, dout, cout, zero);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = OP_PASS;
        amt    = 3'd0;
        din    = 8'h00;
        cin    = 1'b0;
        #1;
        test_reset();
        test_rol();
        test_asr();
        test_rotate_carry();
        test_zero_and_amt0();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
